// File: rtl/paddle_control.sv
// Paddle position controller: pushbutton sync + debounce, direction FSM,
// step divider and clamped horizontal position register.
module paddle_control #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned STEP_DIV        = 100000,
    parameter int unsigned PADDLE_W        = 80,
    parameter int unsigned SCREEN_W        = 640,
    parameter int unsigned START_X         = 280
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       center_req,
    output logic [9:0] paddle_location,
    output logic [1:0] paddle_dir
);

    localparam int unsigned LOC_W = 10;
    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned ST_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned NBTN  = 2;

    localparam logic [LOC_W-1:0] MAX_X   = LOC_W'(SCREEN_W - PADDLE_W);
    localparam logic [LOC_W-1:0] INIT_X  = LOC_W'(START_X);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0]  ST_LAST = ST_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MOVE_L = 2'b01,
        ST_MOVE_R = 2'b10
    } state_t;

    // bit 0 = left, bit 1 = right
    logic [NBTN-1:0]  r_sync1;
    logic [NBTN-1:0]  r_sync2;
    logic [NBTN-1:0]  r_db;
    logic [DB_W-1:0]  r_db_cnt [NBTN];

    state_t           r_state;
    state_t           w_state_next;
    state_t           r_dir;

    logic [ST_W-1:0]  r_step_cnt;
    logic [LOC_W-1:0] r_loc;

    logic             w_moving;
    logic             w_dir_stable;
    logic             w_step;

    // Two-flop synchronizer for the raw buttons
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {btn_right, btn_left};
            r_sync2 <= r_sync1;
        end
    end

    // Per-button debouncer: accept a new level after DEBOUNCE_CYCLES stable samples
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_db <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NBTN); i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Direction FSM state register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Direction FSM next state from the debounced levels only
    always_comb begin
        w_state_next = ST_IDLE;
        case (r_db)
            2'b01:   w_state_next = ST_MOVE_L;
            2'b10:   w_state_next = ST_MOVE_R;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Registered copy of the FSM state drives paddle_dir and the mover
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_dir <= ST_IDLE;
        end else begin
            r_dir <= r_state;
        end
    end

    // A pending direction change (r_dir lagging r_state) restarts the step period
    assign w_moving     = (r_dir != ST_IDLE);
    assign w_dir_stable = (r_dir == r_state);
    assign w_step       = w_moving && w_dir_stable && (r_step_cnt == ST_LAST);

    // Step divider: counts only while steadily moving, cleared by recenter
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_step_cnt <= '0;
        end else if (center_req || !w_moving || !w_dir_stable || w_step) begin
            r_step_cnt <= '0;
        end else begin
            r_step_cnt <= r_step_cnt + ST_W'(1);
        end
    end

    // Position register: recenter wins, otherwise clamp-checked single-pixel step
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_loc <= INIT_X;
        end else if (center_req) begin
            r_loc <= INIT_X;
        end else if (w_step) begin
            if ((r_dir == ST_MOVE_L) && (r_loc != '0)) begin
                r_loc <= r_loc - LOC_W'(1);
            end else if ((r_dir == ST_MOVE_R) && (r_loc != MAX_X)) begin
                r_loc <= r_loc + LOC_W'(1);
            end
        end
    end

    assign paddle_location = r_loc;
    assign paddle_dir      = 2'(r_dir);

endmodule

// File: tb/tb_paddle_control.sv
// Directed bench for paddle_control with DEBOUNCE_CYCLES=4, STEP_DIV=3.
module tb_paddle_control;

    logic       Clock;
    logic       Reset_n;
    logic       btn_left;
    logic       btn_right;
    logic       center_req;
    logic       b_right;
    logic       c_left;
    logic       zero;
    logic [9:0] loc_a;
    logic [1:0] dir_a;
    logic [9:0] loc_b;
    logic [1:0] dir_b;
    logic [9:0] loc_c;
    logic [1:0] dir_c;

    int checks;
    int failures;
    int edge_i;

    paddle_control #(.DEBOUNCE_CYCLES(4), .STEP_DIV(3), .START_X(280)) u_dut_a (
        .Clock(Clock), .Reset_n(Reset_n), .btn_left(btn_left), .btn_right(btn_right),
        .center_req(center_req), .paddle_location(loc_a), .paddle_dir(dir_a)
    );

    paddle_control #(.DEBOUNCE_CYCLES(4), .STEP_DIV(3), .START_X(558)) u_dut_b (
        .Clock(Clock), .Reset_n(Reset_n), .btn_left(zero), .btn_right(b_right),
        .center_req(center_req), .paddle_location(loc_b), .paddle_dir(dir_b)
    );

    paddle_control #(.DEBOUNCE_CYCLES(4), .STEP_DIV(3), .START_X(1)) u_dut_c (
        .Clock(Clock), .Reset_n(Reset_n), .btn_left(c_left), .btn_right(zero),
        .center_req(center_req), .paddle_location(loc_c), .paddle_dir(dir_c)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to #1 after edge n, counting from the last reference point
    task automatic step_to(input int n);
        while (edge_i < n) begin
            @(posedge Clock);
            #1;
            edge_i++;
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        edge_i     = 0;
        Reset_n    = 1'b1;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        center_req = 1'b0;
        b_right    = 1'b0;
        c_left     = 1'b0;
        zero       = 1'b0;

        // Asynchronous reset mid-cycle
        repeat (2) @(posedge Clock);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("rst_loc_a", loc_a, 10'd280);
        chk("rst_dir_a", {8'd0, dir_a}, 10'd0);
        chk("rst_loc_b", loc_b, 10'd558);
        chk("rst_loc_c", loc_c, 10'd1);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        edge_i = -1;
        step_to(2);
        chk("post_rst_loc", loc_a, 10'd280);
        chk("post_rst_dir", {8'd0, dir_a}, 10'd0);

        // Hold right, then add left, release right, release left
        btn_right = 1'b1;
        edge_i = -1;
        step_to(6);  chk("r_dir_e6", {8'd0, dir_a}, 10'd0);
        step_to(7);  chk("r_dir_e7", {8'd0, dir_a}, 10'd2);
                     chk("r_loc_e7", loc_a, 10'd280);
        step_to(9);  chk("r_loc_e9", loc_a, 10'd280);
        step_to(10); chk("r_loc_e10", loc_a, 10'd281);
        step_to(11); btn_left = 1'b1;
        step_to(12); chk("r_loc_e12", loc_a, 10'd281);
        step_to(13); chk("r_loc_e13", loc_a, 10'd282);
        step_to(16); chk("r_loc_e16", loc_a, 10'd283);
        step_to(18); chk("both_dir_e18", {8'd0, dir_a}, 10'd2);
        step_to(19); chk("both_dir_e19", {8'd0, dir_a}, 10'd0);
                     chk("both_loc_e19", loc_a, 10'd283);
        step_to(25); chk("both_loc_e25", loc_a, 10'd283);
        btn_right = 1'b0;
        step_to(32); chk("l_dir_e32", {8'd0, dir_a}, 10'd0);
        step_to(33); chk("l_dir_e33", {8'd0, dir_a}, 10'd1);
        step_to(35); chk("l_loc_e35", loc_a, 10'd283);
        step_to(36); chk("l_loc_e36", loc_a, 10'd282);
        step_to(39); chk("l_loc_e39", loc_a, 10'd281);
        btn_left = 1'b0;
        step_to(46); chk("rel_dir_e46", {8'd0, dir_a}, 10'd1);
        step_to(47); chk("rel_dir_e47", {8'd0, dir_a}, 10'd0);
                     chk("rel_loc_e47", loc_a, 10'd279);

        // Recenter while idle
        center_req = 1'b1;
        step_to(48);
        center_req = 1'b0;
        chk("center_idle", loc_a, 10'd280);

        // 3-clock glitch is rejected
        edge_i = -1;
        btn_left = 1'b1;
        step_to(2);
        btn_left = 1'b0;
        step_to(5);  chk("glitch_dir_e5", {8'd0, dir_a}, 10'd0);
        step_to(12); chk("glitch_dir_e12", {8'd0, dir_a}, 10'd0);
                     chk("glitch_loc_e12", loc_a, 10'd280);

        // 6-clock press is accepted
        edge_i = -1;
        btn_left = 1'b1;
        step_to(5);
        btn_left = 1'b0;
        step_to(6);  chk("p6_dir_e6", {8'd0, dir_a}, 10'd0);
        step_to(7);  chk("p6_dir_e7", {8'd0, dir_a}, 10'd1);
        step_to(12); chk("p6_dir_e12", {8'd0, dir_a}, 10'd1);
        step_to(13); chk("p6_dir_e13", {8'd0, dir_a}, 10'd0);
                     chk("p6_loc_e13", loc_a, 10'd279);

        // Recenter, run right to 300, recenter on a step edge, then reset mid-move
        edge_i = -1;
        center_req = 1'b1;
        step_to(0);
        center_req = 1'b0;
        chk("center2", loc_a, 10'd280);
        edge_i = -1;
        btn_right = 1'b1;
        step_to(67); chk("run_loc_300", loc_a, 10'd300);
                     chk("run_dir", {8'd0, dir_a}, 10'd2);
        step_to(69);
        center_req = 1'b1;
        step_to(70);
        center_req = 1'b0;
        chk("cr_step_e70", loc_a, 10'd280);
        step_to(72); chk("cr_loc_e72", loc_a, 10'd280);
        step_to(73); chk("cr_loc_e73", loc_a, 10'd281);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_loc", loc_a, 10'd280);
        chk("mid_rst_dir", {8'd0, dir_a}, 10'd0);
        @(posedge Clock);
        #1;
        btn_right = 1'b0;
        Reset_n = 1'b1;
        edge_i = -1;
        step_to(2);
        chk("rst2_loc", loc_a, 10'd280);

        // Clamp at both screen edges
        edge_i = -1;
        b_right = 1'b1;
        c_left = 1'b1;
        step_to(7);  chk("clamp_dir_b", {8'd0, dir_b}, 10'd2);
                     chk("clamp_dir_c", {8'd0, dir_c}, 10'd1);
        step_to(10); chk("clamp_b_e10", loc_b, 10'd559);
                     chk("clamp_c_e10", loc_c, 10'd0);
        step_to(12); chk("clamp_b_e12", loc_b, 10'd559);
        step_to(13); chk("clamp_b_e13", loc_b, 10'd560);
                     chk("clamp_c_e13", loc_c, 10'd0);
        step_to(43); chk("clamp_b_e43", loc_b, 10'd560);
                     chk("clamp_c_e43", loc_c, 10'd0);
                     chk("clamp_dir_b_e43", {8'd0, dir_b}, 10'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/paddle_control.md
Name: paddle_control

Overview:
- Upstream of the ball movement stage; produces `paddle_location`, which the ball stage uses for its hit test at `ball_y == 436`.
- Converts two raw board pushbuttons into a clamped horizontal paddle position, moving one pixel per step tick.
- Contains a 2-flop synchronizer, a per-button debouncer, a 3-state direction FSM, a step divider and a position register with clamp.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synced samples required to accept a new button level.
- STEP_DIV, 100000: clocks per one-pixel paddle step while moving.
- PADDLE_W, 80: paddle width in pixels.
- SCREEN_W, 640: visible width in pixels.
- START_X, 280: paddle location after reset or recenter.

Ports:
- Clock  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- btn_left  in  1  raw pushbutton, active high, asynchronous to Clock.
- btn_right  in  1  raw pushbutton, active high, asynchronous to Clock.
- center_req  in  1  synchronous single-cycle pulse; recenters the paddle.
- paddle_location  out  10  left edge of the paddle, range 0..SCREEN_W-PADDLE_W (0..560).
- paddle_dir  out  2  00 idle, 01 moving left, 10 moving right; 11 never driven.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - paddle_location = START_X; paddle_dir = 00; FSM = IDLE.
  - Synchronizer flops, debounced levels and all counters = 0.
  - Effect is immediate; no clock is required. Reset mid-move discards any partial step count.
- Synchronizer: each button passes through 2 flops. Only the second-flop output is used downstream.
- Debouncer, one per button:
  - 0..DEBOUNCE_CYCLES-1 counter. Cleared on any edge where the synced value equals the debounced value.
  - Otherwise increments. The edge where it would reach DEBOUNCE_CYCLES loads the debounced value with the synced value and clears the counter.
  - Glitches shorter than DEBOUNCE_CYCLES are therefore ignored.
- FSM states: IDLE, MOVE_L, MOVE_R. Next state depends only on the debounced levels L and R:
  - L=1, R=0 -> MOVE_L.
  - L=0, R=1 -> MOVE_R.
  - L=R (both or neither) -> IDLE.
- Press latency: a button change reaches the FSM state 2 (sync) + DEBOUNCE_CYCLES + 1 rising edges after the change.
- paddle_dir is a registered copy of the FSM state: IDLE=00, MOVE_L=01, MOVE_R=10.
- Step divider:
  - Counts 0..STEP_DIV-1 only while in MOVE_L or MOVE_R.
  - Forced to 0 in IDLE and on any state change, including MOVE_L <-> MOVE_R.
  - A step fires on the edge where the count equals STEP_DIV-1; the count then wraps to 0.
  - The first step lands STEP_DIV edges after entering a move state.
- Position update on a step:
  - MOVE_L: location - 1, unless location == 0 (hold).
  - MOVE_R: location + 1, unless location == SCREEN_W-PADDLE_W (hold).
  - The value never leaves 0..560; no wrap-around. Unsigned 10-bit arithmetic; the bounds check is done before the add/subtract.
- center_req:
  - On the edge where it is high, paddle_location = START_X and the step counter = 0.
  - It takes priority over a coincident step. FSM state is unaffected.
- Simultaneous press or release of both buttons within the debounce window: the FSM follows the debounced levels edge by edge. A transient MOVE state of fewer than STEP_DIV cycles produces no step.
- paddle_location is glitch-free (fully registered) and changes by at most 1 per clock, except on recenter or reset.

Test Plan (DEBOUNCE_CYCLES=4, STEP_DIV=3 unless stated):
- Reset: drive Reset_n low mid-clock with no edge -> paddle_location=280 and paddle_dir=00 immediately; both stay after release with buttons idle.
- Hold btn_right from edge 0 -> paddle_dir=10 after edge 7; location 281 at edge 10, 282 at edge 13; increments every 3 edges.
- Bounce: pulse btn_left high for 3 clocks, then low -> paddle_dir stays 00 and location stays 280. A 6-clock pulse -> dir=01 for the held period, then back to 00.
- Clamp: START_X=558, hold btn_right -> location 559, 560, then holds 560 for 10 more steps. Mirror case: START_X=1, hold btn_left -> 0, then holds.
- Both buttons: hold right until location=283, then also press left -> after debounce dir=00 and location frozen at 283. Release right -> dir=01, first decrement STEP_DIV edges after entering MOVE_L.
- center_req on the same edge a step would fire while at 300 moving right -> location=280 next edge; next step 3 edges later gives 281; reset asserted during the move returns 280/00 asynchronously.
